lcd_bus_receiver: RTL

- Responder-side model of the 4-bit HD44780-style character LCD bus (SF_D[11:8], LCD_RS, LCD_RW, LCD_EN) driven by instruction_fsm.
- Latches nibbles on the LCD_EN falling edge and tracks the power-on 4-bit init sequence.
- Reassembles bytes, classifies each byte as command or data, and tracks the DDRAM address.
- Flags protocol and timing violations. Used in simulation benches and in-FPGA as a self-check monitor on the same clk.

---
 rtl/lcd_bus_receiver_if.sv | 11 +
 rtl/lcd_bus_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver_if.sv
// lcd_bus_receiver_if: 4-bit HD44780-style character LCD bus.
// The master drives the strobe and nibble lines. The slave observes them.
interface lcd_bus_receiver_if;
   logic [11:8] SF_D;
   logic        LCD_RS;
   logic        LCD_RW;
   logic        LCD_EN;

   modport master (output SF_D, output LCD_RS, output LCD_RW, output LCD_EN);
   modport slave  (input  SF_D, input  LCD_RS, input  LCD_RW, input  LCD_EN);
endinterface

// File: rtl/lcd_bus_receiver.sv
// lcd_bus_receiver: responder-side monitor for the 4-bit character LCD bus.
// Nibbles are latched on LCD_EN falling edges. The module tracks the power-on
// 3,3,3,2 init sequence, rebuilds bytes, classifies them as command or data,
// and follows the DDRAM address. Protocol errors are always flagged.
// Optional feature macro: LCDRX_TIMING_CHECK_EN. When it is defined, gap and
// EN-width timing checks drive busy and timing_err. When it is undefined, both
// outputs are tied 0 and the timers are not built.
module lcd_bus_receiver #(
   parameter int EN_MIN_CYC  = 12,
   parameter int NIB_GAP_CYC = 50,
   parameter int CMD_GAP_CYC = 2000,
   parameter int CLR_GAP_CYC = 82000
) (
   input  logic                 clk,
   input  logic                 reset,
   lcd_bus_receiver_if.slave    bus,
   output logic                 byte_valid,
   output logic [7:0]           byte_data,
   output logic                 byte_is_data,
   output logic [6:0]           ddram_addr,
   output logic                 init_done,
   output logic                 busy,
   output logic                 proto_err,
   output logic                 timing_err
);

   typedef enum logic [2:0] {INIT3_A, INIT3_B, INIT3_C, INIT2, HI, LO} state_t;

   state_t      state;
   state_t      state_next;
   logic        en_q;
   logic        en_fall;
   logic        write_fall;
   logic [3:0]  nib;
   logic [3:0]  hi_nib;
   logic        hi_rs;
   logic [7:0]  new_byte;
   logic        is_clear;
   logic [6:0]  addr_next;

   logic        init_nibble;
   logic        init_enter;
   logic        hi_take;
   logic        byte_done;
   logic        proto_set;

   assign nib        = bus.SF_D;
   assign en_fall    = en_q & ~bus.LCD_EN;
   assign write_fall = en_fall & ~bus.LCD_RW;
   assign new_byte   = {hi_nib, nib};
   assign is_clear   = (new_byte == 8'h01) || (new_byte == 8'h02) || (new_byte == 8'h03);

   // State register and the one-cycle EN copy used for edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= INIT3_A;
         en_q  <= 1'b0;
      end else begin
         state <= state_next;
         en_q  <= bus.LCD_EN;
      end
   end

   // Next state: only write strobes move the machine, read strobes are ignored
   always_comb begin
      state_next = state;
      if (write_fall) begin
         case (state)
            INIT3_A: state_next = (nib == 4'h3) ? INIT3_B : INIT3_A;
            INIT3_B: state_next = (nib == 4'h3) ? INIT3_C : INIT3_A;
            INIT3_C: state_next = (nib == 4'h3) ? INIT2   : INIT3_A;
            INIT2:   state_next = (nib == 4'h2) ? HI      : INIT3_A;
            HI:      state_next = LO;
            LO:      state_next = HI;
            default: state_next = INIT3_A;
         endcase
      end
   end

   // Per-strobe decode: which action this EN fall triggers and whether it breaks protocol
   always_comb begin
      init_nibble = 1'b0;
      init_enter  = 1'b0;
      hi_take     = 1'b0;
      byte_done   = 1'b0;
      proto_set   = 1'b0;
      if (en_fall && bus.LCD_RW) begin
         proto_set = 1'b1;
      end else if (write_fall) begin
         case (state)
            INIT3_A, INIT3_B, INIT3_C: init_nibble = 1'b1;
            INIT2: begin
               init_nibble = 1'b1;
               if (nib == 4'h2) init_enter = 1'b1;
               else             proto_set  = 1'b1;
            end
            HI: hi_take = 1'b1;
            LO: begin
               byte_done = 1'b1;
               if (bus.LCD_RS != hi_rs) proto_set = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // DDRAM address after the byte being completed; data wraps line 1 to line 2 and back
   always_comb begin
      addr_next = ddram_addr;
      if (hi_rs) begin
         if (ddram_addr == 7'h27)      addr_next = 7'h40;
         else if (ddram_addr == 7'h67) addr_next = 7'h00;
         else                          addr_next = ddram_addr + 7'd1;
      end else if (new_byte[7]) begin
         addr_next = new_byte[6:0];
      end else if (is_clear) begin
         addr_next = 7'h00;
      end
   end

   // Byte assembly, address tracking and sticky protocol flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_valid   <= 1'b0;
         byte_data    <= 8'h00;
         byte_is_data <= 1'b0;
         ddram_addr   <= 7'h00;
         init_done    <= 1'b0;
         proto_err    <= 1'b0;
         hi_nib       <= 4'h0;
         hi_rs        <= 1'b0;
      end else begin
         byte_valid <= byte_done;
         if (hi_take) begin
            hi_nib <= nib;
            hi_rs  <= bus.LCD_RS;
         end
         if (byte_done) begin
            byte_data    <= new_byte;
            byte_is_data <= hi_rs;
            ddram_addr   <= addr_next;
         end
         if (init_enter) init_done <= 1'b1;
         if (proto_set)  proto_err <= 1'b1;
      end
   end

`ifdef LCDRX_TIMING_CHECK_EN
   localparam int TW = $clog2(CLR_GAP_CYC + 1);
   localparam int EW = $clog2(EN_MIN_CYC + 1);

   logic [TW-1:0] gap_timer;
   logic [EW-1:0] en_width;
   logic [3:0]    sfd_q;
   logic          rs_q;
   logic          en_rise;
   logic          gap_viol;
   logic          width_viol;
   logic          hold_viol;

   assign en_rise    = bus.LCD_EN & ~en_q;
   assign busy       = (gap_timer != '0);
   // A rise in the cycle the timer steps from 1 to 0 counts as on time.
   assign gap_viol   = en_rise && (gap_timer > TW'(1));
   assign width_viol = en_fall && (en_width < EW'(EN_MIN_CYC - 1));
   assign hold_viol  = bus.LCD_EN && en_q && ((nib != sfd_q) || (bus.LCD_RS != rs_q));

   // Gap timer: reloaded by each accepted nibble, otherwise counts down to 0 and holds
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_timer <= '0;
      end else if (byte_done) begin
         gap_timer <= is_clear ? TW'(CLR_GAP_CYC) : TW'(CMD_GAP_CYC);
      end else if (hi_take) begin
         gap_timer <= TW'(NIB_GAP_CYC);
      end else if (init_nibble) begin
         gap_timer <= TW'(CMD_GAP_CYC);
      end else if (gap_timer != '0) begin
         gap_timer <= gap_timer - 1'b1;
      end
   end

   // EN high-width counter plus the bus copies used to spot changes mid-strobe
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_width <= '0;
         sfd_q    <= 4'h0;
         rs_q     <= 1'b0;
      end else begin
         sfd_q <= nib;
         rs_q  <= bus.LCD_RS;
         if (en_rise)
            en_width <= '0;
         else if (bus.LCD_EN && (en_width != EW'(EN_MIN_CYC)))
            en_width <= en_width + 1'b1;
      end
   end

   // Sticky timing flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timing_err <= 1'b0;
      else if (gap_viol || width_viol || hold_viol)
         timing_err <= 1'b1;
   end
`else
   // Timing parameters and the init-load strobe only matter to the timing checks.
   logic unused_timing;
   assign unused_timing = init_nibble ^
                          ((EN_MIN_CYC + NIB_GAP_CYC + CMD_GAP_CYC + CLR_GAP_CYC) != 0);
   assign busy       = 1'b0;
   assign timing_err = 1'b0;
`endif

endmodule
